// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational ALU between
// two requesters and returns each tagged result over a response handshake.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [OPW-1:0]   r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [OPW-1:0]   r1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_s,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_s,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             prio_q;
  logic             id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] res_q;
  logic             grant_id;
  logic             accept;

  // On a tie the pointer decides; a lone requester wins regardless of it.
  always_comb begin
    state_d  = state_q;
    grant_id = 1'b0;
    accept   = 1'b0;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_id = prio_q;
    end else begin
      grant_id = r1_valid;
    end
    case (state_q)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          accept   = 1'b1;
          r0_ready = !grant_id;
          r1_ready = grant_id;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands stay registered after the transaction so the ALU inputs hold steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      id_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        prio_q <= !grant_id;
        id_q   <= grant_id;
        a_q    <= grant_id ? r1_a  : r0_a;
        b_q    <= grant_id ? r1_b  : r0_b;
        op_q   <= grant_id ? r1_op : r0_op;
      end
      if (state_q == EXEC) begin
        res_q <= alu_s;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign resp_s     = res_q;
  assign resp_id    = id_q;
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);

endmodule
